// File: rtl/sprite_dma.sv
// Sprite DMA: on a CPU write to $4014, halts the CPU and copies page {page,$00..$FF} to $2004.
// Flow: one HALT cycle, an optional ALIGN cycle when parity is odd, then 256 READ/WRITE pairs.
module sprite_dma (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        halt,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [15:0] TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_ADDR  = 16'h2004;

    state_t     state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] byte_q,  byte_d;
    logic       parity_q, parity_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            byte_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            byte_q   <= byte_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        byte_d   = byte_q;
        parity_d = ~parity_q;

        case (state_q)
            S_IDLE: begin
                if (!cpu_rw && cpu_addr == TRIG_ADDR) begin
                    page_d  = cpu_wdata;
                    index_d = 8'h00;
                    state_d = S_HALT;
                end
            end
            // Odd parity at the end of HALT needs one extra cycle to land READ on the right phase.
            S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                byte_d  = mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                index_d = index_q + 8'h01;
                state_d = (index_q == 8'hFF) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        halt       = (state_q != S_IDLE);
        dma_active = (state_q != S_IDLE);
        dma_addr   = 16'h0000;
        dma_rw     = 1'b1;
        dma_wdata  = 8'h00;

        case (state_q)
            // Dummy read of whatever the stalled CPU presents; never a write.
            S_HALT, S_ALIGN: dma_addr = cpu_addr;
            S_READ:          dma_addr = {page_q, index_q};
            S_WRITE: begin
                dma_addr  = OAM_ADDR;
                dma_rw    = 1'b0;
                dma_wdata = byte_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sprite_dma.md
SPRITE_DMA -- requirements
Module: sprite_dma

Interface
REQ-001 clock  input  1  system clock (CPU cycle rate); all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; forces reset state immediately while high.
REQ-003 cpu_addr  input  16  CPU address bus.
REQ-004 cpu_rw  input  1  CPU read/write (1 = read, 0 = write).
REQ-005 cpu_wdata  input  8  CPU write data.
REQ-006 mem_rdata  input  8  data returned by memory during DMA read cycles (valid at rising edge ending the cycle).
REQ-007 halt  output  1  high = CPU must stall; no bus cycle from CPU.
REQ-008 dma_active  output  1  high = bus mux selects DMA address/rw/data, not CPU.
REQ-009 dma_addr  output  16  DMA-driven address.
REQ-010 dma_rw  output  1  DMA-driven read/write.
REQ-011 dma_wdata  output  8  DMA-driven write data.

Function
REQ-012 Trigger: rising edge with cpu_rw=0 and cpu_addr=$4014 while state=IDLE SHALL latch cpu_wdata into page register and enter HALT.
REQ-013 Writes to $4014 while not IDLE SHALL be ignored; page register unchanged.
REQ-014 Parity: 1-bit cycle counter SHALL toggle every rising edge; value 0 on the first edge after reset deassert.
REQ-015 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-016 HALT lasts exactly 1 cycle; next state ALIGN if parity=1 at that edge, else READ.
REQ-017 ALIGN lasts exactly 1 cycle, then READ.
REQ-018 READ: dma_addr = {page, index}, dma_rw=1; at cycle end mem_rdata captured into byte register; next WRITE.
REQ-019 WRITE: dma_addr=$2004, dma_rw=0, dma_wdata = byte register; at cycle end index increments (8-bit, wraps).
REQ-020 After WRITE with index=$FF: next IDLE; else next READ.
REQ-021 Total DMA duration: 513 cycles (parity even) or 514 cycles (parity odd), trigger cycle excluded.
REQ-022 halt and dma_active SHALL be high in HALT, ALIGN, READ, WRITE; low in IDLE.
REQ-023 In HALT and ALIGN: dma_addr = cpu_addr, dma_rw=1 (dummy read, no write side-effect).
REQ-024 In IDLE: dma_addr=$0000, dma_rw=1, dma_wdata=$00.
REQ-025 index SHALL be $00 on every entry to HALT; page $00 must source $0000-$00FF, page $FF must source $FF00-$FFFF (no carry into page).
REQ-026 Exactly 256 writes to $2004 per trigger, in ascending source order.

Reset
REQ-027 reset high SHALL asynchronously force state=IDLE, page=$00, index=$00, byte=$00, parity=0; halt=0, dma_active=0, dma_addr=$0000, dma_rw=1, dma_wdata=$00.
REQ-028 reset mid-transfer SHALL abort without further writes; after release, block waits for a new trigger.

Verification
REQ-029 Memory $0200-$02FF = index value; write $02 to $4014 on even parity -> halt high 513 cycles, 256 writes to $2004 carrying $00..$FF in order.
REQ-030 Same on odd parity -> halt high 514 cycles, first READ of $0200 one cycle later, data identical.
REQ-031 Second write $05 to $4014 during transfer -> ignored; all reads remain from page $02.
REQ-032 Page $FF with memory $FF00-$FFFF preset -> last read address $FFFF, no access to $0000 range.
REQ-033 Assert reset after 100th write -> halt/dma_active low immediately (same cycle), no further $2004 writes; new trigger after release completes all 256.
REQ-034 Read (cpu_rw=1) of $4014 and write to $4015 -> no trigger, halt stays 0.
